ap_job_seq: RTL and testbench
=============================

AP_JOB_SEQ -- requirements
Module: ap_job_seq

Interface
REQ-001 SHALL have parameter CELL_QUANT, default 512, meaning number of AP rows.
REQ-002 SHALL have parameter WORD_SIZE, default 8, meaning bits per AP column word.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles to wait for ap_state_irq.
REQ-004 SHALL derive localparam AW = clogb2(CELL_QUANT) and LW = AW+1.
REQ-005 SHALL have CLK100MHZ  in  1  sole clock; one clock, all state on its rising edge.
REQ-006 SHALL have rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have start  in  1  one-cycle job request, accepted only in IDLE.
REQ-008 SHALL have job_cmd  in  3  AP operation code forwarded to ap_cmd.
REQ-009 SHALL have job_len  in  LW  number of rows to load, run and read back.
REQ-010 SHALL have in_valid / in_ready / in_data  in / out / in  1 / 1 / WORD_SIZE  operand stream: job_len A words, then job_len B words.
REQ-011 SHALL have out_valid / out_ready / out_data  out / in / out  1 / 1 / WORD_SIZE  result stream of column C.
REQ-012 SHALL have ap_addr, ap_data, ap_sel_col, ap_write_en, ap_read_en, ap_mode, ap_cmd  out  AW, WORD_SIZE, 2, 1, 1, 1, 3  AP drive signals.
REQ-013 SHALL have ap_data_out  in  WORD_SIZE, and ap_state_irq  in  1, from the AP.
REQ-014 SHALL have busy  out  1, done  out  1 (pulse), err  out  1 (sticky until next accepted start).

Function
REQ-015 SHALL implement states IDLE, LOAD_A, LOAD_B, RUN, READ_REQ, READ_CAP, DRAIN, DONE.
REQ-016 IDLE: on start with 1 <= job_len <= CELL_QUANT, SHALL latch job_cmd/job_len, clear err, row counter=0, go LOAD_A.
REQ-017 IDLE: start with job_len=0 SHALL go DONE without any AP access; job_len > CELL_QUANT SHALL set err and go DONE.
REQ-018 LOAD_A/LOAD_B: in_ready=1; on in_valid&&in_ready SHALL, in the same cycle, drive ap_write_en=1, ap_addr=row, ap_data=in_data, ap_sel_col=0 (A) / 1 (B), then increment row.
REQ-019 After row job_len-1 is written SHALL reset row to 0 and advance LOAD_A->LOAD_B->RUN; in_ready SHALL be 0 in all other states.
REQ-020 RUN: SHALL hold ap_mode=1, ap_cmd=latched cmd, write/read enables 0, and count cycles.
REQ-021 RUN: ap_state_irq=1 SHALL drop ap_mode next cycle and go READ_REQ; if count reaches TIMEOUT first, SHALL set err, drop ap_mode, go DONE.
REQ-022 RUN: irq and timeout in the same cycle SHALL be treated as irq (no err).
REQ-023 READ_REQ: SHALL drive ap_read_en=1, ap_sel_col=2, ap_addr=row for one cycle, go READ_CAP.
REQ-024 READ_CAP: SHALL register ap_data_out into out_data (AP read latency is one cycle), set out_valid, go DRAIN.
REQ-025 DRAIN: SHALL hold out_valid/out_data stable until out_ready; on transfer, row==job_len-1 -> DONE, else row++ and READ_REQ.
REQ-026 At most one read SHALL be in flight; throughput 3 cycles/word with out_ready held high.
REQ-027 DONE: SHALL pulse done for exactly one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start asserted while not IDLE SHALL be ignored.
REQ-030 Row counter SHALL be LW bits; comparisons against job_len-1 SHALL not wrap for job_len=CELL_QUANT.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and zero all outputs, counters and latched fields, including mid-job.
REQ-032 A reset during RUN SHALL deassert ap_mode asynchronously; no AP write or read SHALL occur in the cycle after rst_n rises.

Structure
REQ-033 State enum, column selector constants (COL_A=0, COL_B=1, COL_C=2) and clogb2 SHALL live in shared package ap_pkg.
REQ-034 Single module, no sub-modules; timeout counter inline.

Verification
REQ-035 Reset then start len=4 cmd=3, A={1,2,3,4}, B={10,20,30,40}, irq 20 cycles later -> 8 writes at addr 0..3, sel_col 0 then 1, ap_mode high 20 cycles, 4 reads sel_col 2, out order matches addr 0..3, done pulse once.
REQ-036 len=512 with random in_valid gaps -> last write addr 511 col B, row counter no wrap, 512 outputs.
REQ-037 irq never asserted, TIMEOUT=16 -> ap_mode falls after 16 RUN cycles, err=1, done pulse, no reads.
REQ-038 out_ready low 10 cycles during DRAIN -> out_data stable, no extra ap_read_en.
REQ-039 start len=0 -> done pulse two cycles later, no AP strobes; len=600 -> err=1, done.
REQ-040 rst_n low during LOAD_B and during RUN -> outputs zero immediately, ap_mode 0, then new job completes normally.

Source files
------------

// File: rtl/ap_pkg.sv
// Shared definitions for the associative-processor job sequencer: FSM states,
// AP column selectors and a constant log2 helper for sizing address fields.
package ap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    RUN      = 3'd3,
    READ_REQ = 3'd4,
    READ_CAP = 3'd5,
    DRAIN    = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [1:0] COL_A = 2'd0;
  localparam logic [1:0] COL_B = 2'd1;
  localparam logic [1:0] COL_C = 2'd2;

  // Ceiling log2, never below 1 so degenerate sizes still give a usable width.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ap_job_seq.sv
// Job sequencer for an associative processor: streams operand columns A and B
// into the AP, runs one AP command until its interrupt, then streams column C out.
module ap_job_seq
  import ap_pkg::*;
#(
  parameter int CELL_QUANT = 512,
  parameter int WORD_SIZE  = 8,
  parameter int TIMEOUT    = 4096,
  localparam int AW = clogb2(CELL_QUANT),
  localparam int LW = AW + 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           job_cmd,
  input  logic [LW-1:0]        job_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [AW-1:0]        ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_state_irq,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TW = clogb2(TIMEOUT) + 1;

  state_t          state_reg;
  logic [LW-1:0]   row_reg;
  logic [LW-1:0]   len_reg;
  logic [2:0]      cmd_reg;
  logic [TW-1:0]   tcnt_reg;

  logic loading;
  logic in_fire;
  logic last_row;

  assign loading  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign in_fire  = loading && in_valid;
  // len_reg >= 1 whenever this is used, so the subtraction never wraps.
  assign last_row = (row_reg == len_reg - LW'(1));

  // AP drive is decoded from state so an asynchronous reset silences it at once.
  assign in_ready    = loading;
  assign ap_write_en = in_fire;
  assign ap_read_en  = (state_reg == READ_REQ);
  assign ap_mode     = (state_reg == RUN);
  assign ap_cmd      = ap_mode ? cmd_reg : 3'd0;
  assign ap_addr     = (in_fire || ap_read_en) ? row_reg[AW-1:0] : '0;
  assign ap_data     = in_fire ? in_data : '0;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);

  always_comb begin
    ap_sel_col = COL_A;
    if (in_fire && state_reg == LOAD_B) ap_sel_col = COL_B;
    else if (ap_read_en)                ap_sel_col = COL_C;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      len_reg   <= '0;
      cmd_reg   <= '0;
      tcnt_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (job_len == '0) begin
              state_reg <= DONE;
            end else if (job_len > LW'(CELL_QUANT)) begin
              err       <= 1'b1;
              state_reg <= DONE;
            end else begin
              len_reg   <= job_len;
              cmd_reg   <= job_cmd;
              row_reg   <= '0;
              state_reg <= LOAD_A;
            end
          end
        end

        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            if (last_row) begin
              row_reg   <= '0;
              tcnt_reg  <= '0;
              state_reg <= (state_reg == LOAD_A) ? LOAD_B : RUN;
            end else begin
              row_reg <= row_reg + LW'(1);
            end
          end
        end

        RUN: begin
          // The interrupt wins over a timeout landing in the same cycle.
          if (ap_state_irq) begin
            state_reg <= READ_REQ;
          end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            state_reg <= DONE;
          end else begin
            tcnt_reg <= tcnt_reg + TW'(1);
          end
        end

        READ_REQ: state_reg <= READ_CAP;

        READ_CAP: begin
          out_data  <= ap_data_out;
          out_valid <= 1'b1;
          state_reg <= DRAIN;
        end

        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_row) begin
              state_reg <= DONE;
            end else begin
              row_reg   <= row_reg + LW'(1);
              state_reg <= READ_REQ;
            end
          end
        end

        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_job_seq.sv
// Bench for ap_job_seq: a table of whole jobs against a behavioural AP (C = A + B),
// plus hand-written reset-abort sequences; a TIMEOUT=16 twin shares the stimulus.
module tb_ap_job_seq;
  import ap_pkg::*;

  localparam int CQ = 512;
  localparam int WS = 8;
  localparam int AW = 9;
  localparam int LW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, out_ready, ap_state_irq;
  logic [2:0]    job_cmd;
  logic [LW-1:0] job_len;
  logic [WS-1:0] in_data, ap_data_out;

  logic          in_ready, out_valid, ap_write_en, ap_read_en, ap_mode, busy, done, err;
  logic [WS-1:0] out_data, ap_data;
  logic [AW-1:0] ap_addr;
  logic [1:0]    ap_sel_col;
  logic [2:0]    ap_cmd;

  logic          in_ready_t, out_valid_t, ap_write_en_t, ap_read_en_t, ap_mode_t, busy_t, done_t, err_t;
  logic [WS-1:0] out_data_t, ap_data_t;
  logic [AW-1:0] ap_addr_t;
  logic [1:0]    ap_sel_col_t;
  logic [2:0]    ap_cmd_t;

  ap_job_seq dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .job_cmd(job_cmd), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ap_addr(ap_addr), .ap_data(ap_data), .ap_sel_col(ap_sel_col),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_mode(ap_mode), .ap_cmd(ap_cmd),
    .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq),
    .busy(busy), .done(done), .err(err)
  );

  ap_job_seq #(.TIMEOUT(16)) dut_t (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .job_cmd(job_cmd), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .ap_addr(ap_addr_t), .ap_data(ap_data_t), .ap_sel_col(ap_sel_col_t),
    .ap_write_en(ap_write_en_t), .ap_read_en(ap_read_en_t), .ap_mode(ap_mode_t), .ap_cmd(ap_cmd_t),
    .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq),
    .busy(busy_t), .done(done_t), .err(err_t)
  );

  // Behavioural AP: columns A and B, column C reads back A+B one cycle later.
  logic [WS-1:0] mem_a [0:CQ-1];
  logic [WS-1:0] mem_b [0:CQ-1];
  always @(posedge clk) begin
    if (ap_write_en) begin
      if (ap_sel_col == COL_B) mem_b[ap_addr] <= ap_data;
      else                     mem_a[ap_addr] <= ap_data;
    end
    if (ap_read_en) ap_data_out <= mem_a[ap_addr] + mem_b[ap_addr];
  end

  int cur_len = 1;
  int cur_cmd = 0;

  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, mode_cnt = 0;
  int rd_cnt_t = 0, done_cnt_t = 0, mode_cnt_t = 0;
  int out_cnt = 0, ord_bad = 0, stab_bad = 0, cyc = 0;
  int job_wr_idx = 0, job_rd_idx = 0, first_rd = 0, last_rd = 0;
  logic [WS-1:0] out_mem [0:1023];
  logic          prev_hold = 1'b0;
  logic [WS-1:0] prev_od = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && rst_n) begin
      job_wr_idx <= 0;
      job_rd_idx <= 0;
    end
    if (ap_write_en) begin
      wr_cnt     <= wr_cnt + 1;
      job_wr_idx <= job_wr_idx + 1;
      if (ap_addr != AW'(job_wr_idx % cur_len) || ap_data != in_data || !in_ready ||
          ap_sel_col != ((job_wr_idx < cur_len) ? COL_A : COL_B))
        ord_bad <= ord_bad + 1;
    end
    if (ap_write_en_t && (ap_addr_t != ap_addr || ap_data_t != ap_data ||
                          ap_sel_col_t != ap_sel_col || !in_ready_t))
      ord_bad <= ord_bad + 1;
    if (ap_read_en) begin
      rd_cnt     <= rd_cnt + 1;
      job_rd_idx <= job_rd_idx + 1;
      if (job_rd_idx == 0) first_rd <= cyc;
      last_rd <= cyc;
      if (ap_addr != AW'(job_rd_idx) || ap_sel_col != COL_C || ap_write_en || out_valid || ap_mode)
        ord_bad <= ord_bad + 1;
    end
    if (ap_mode) begin
      mode_cnt <= mode_cnt + 1;
      if (ap_cmd != 3'(cur_cmd) || ap_write_en || ap_read_en) ord_bad <= ord_bad + 1;
    end
    if (ap_mode_t) begin
      mode_cnt_t <= mode_cnt_t + 1;
      if (ap_cmd_t != 3'(cur_cmd)) ord_bad <= ord_bad + 1;
    end
    if (ap_read_en_t) rd_cnt_t <= rd_cnt_t + 1;
    if (done)   done_cnt   <= done_cnt + 1;
    if (done_t) done_cnt_t <= done_cnt_t + 1;
    if (out_valid && out_valid_t && out_data_t != out_data) ord_bad <= ord_bad + 1;
    if (out_valid && out_ready) begin
      out_mem[out_cnt % 1024] <= out_data;
      out_cnt <= out_cnt + 1;
    end
    if (prev_hold && rst_n && (!out_valid || out_data != prev_od)) stab_bad <= stab_bad + 1;
    prev_hold <= rst_n && out_valid && !out_ready && !busy_t && busy ? 1'b1 : (rst_n && out_valid && !out_ready);
    prev_od   <= out_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len; int cmd; int irq_delay; int rm; int gaps;
    int exp_wr; int exp_rd; int exp_mode; int exp_err;
  } vec_t;

  vec_t vecs [8];
  logic [WS-1:0] a_v [0:CQ-1];
  logic [WS-1:0] b_v [0:CQ-1];

  task automatic gen_data(input int len);
    for (int i = 0; i < len && i < CQ; i++) begin
      a_v[i] = WS'($urandom_range(0, 255));
      b_v[i] = WS'($urandom_range(0, 255));
    end
  endtask

  task automatic start_job(input int len, input int cmd);
    @(posedge clk); #1;
    start = 1'b1; job_len = LW'(len); job_cmd = 3'(cmd);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gaps, input string tag);
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = (k < cur_len) ? a_v[k] : b_v[k - cur_len];
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        chk({tag, ".feed_timeout"}, k, n);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_run(input int irq_delay, input string tag);
    int  m;
    bit  fin;
    m = 0; fin = 1'b0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      @(negedge clk);
      if (ap_mode) begin
        m++;
        ap_state_irq = (irq_delay != 0 && m == irq_delay);
      end else begin
        ap_state_irq = 1'b0;
        if (m > 0 || !busy) fin = 1'b1;
      end
    end
    if (!fin) chk({tag, ".run_timeout"}, m, -1);
  endtask

  task automatic drain(input int rm, input int done_base, input string tag);
    int c;
    c = 0;
    while (done_cnt == done_base && c < 4000) begin
      @(posedge clk); #1;
      case (rm)
        1:       out_ready = (c >= 13);
        2:       out_ready = (c % 3 != 0);
        default: out_ready = 1'b1;
      endcase
      c++;
    end
    if (done_cnt == done_base) chk({tag, ".drain_timeout"}, c, -1);
    out_ready = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int tag);
    int wr_b, rd_b, dn_b, md_b, out_b, ord_b, stb_b, rdt_b, dnt_b, mdt_b, n_out;
    string t;
    logic [WS-1:0] e;
    bit ok_len;
    t = $sformatf("job%0d", tag);
    ok_len = (v.len >= 1 && v.len <= CQ);
    wr_b = wr_cnt; rd_b = rd_cnt; dn_b = done_cnt; md_b = mode_cnt; out_b = out_cnt;
    ord_b = ord_bad; stb_b = stab_bad; rdt_b = rd_cnt_t; dnt_b = done_cnt_t; mdt_b = mode_cnt_t;
    cur_len = ok_len ? v.len : 1;
    cur_cmd = v.cmd;
    gen_data(v.len);
    start_job(v.len, v.cmd);
    if (ok_len) begin
      feed(2 * v.len, v.gaps, t);
      wait_run(v.irq_delay, t);
    end
    drain(v.rm, dn_b, t);
    repeat (2) @(negedge clk);
    n_out = out_cnt - out_b;
    chk({t, ".done_pulses"}, done_cnt - dn_b, 1);
    chk({t, ".writes"},      wr_cnt - wr_b, v.exp_wr);
    chk({t, ".reads"},       rd_cnt - rd_b, v.exp_rd);
    chk({t, ".mode_cycles"}, mode_cnt - md_b, v.exp_mode);
    chk({t, ".err"},         err, v.exp_err);
    chk({t, ".busy_after"},  busy, 0);
    chk({t, ".outputs"},     n_out, v.exp_rd);
    chk({t, ".order"},       ord_bad - ord_b, 0);
    chk({t, ".stable"},      stab_bad - stb_b, 0);
    for (int i = 0; i < v.exp_rd && i < n_out; i++) begin
      e = a_v[i] + b_v[i];
      chk($sformatf("%s.out_data[%0d]", t, i), out_mem[(out_b + i) % 1024], e);
    end
    if (v.rm == 0 && v.exp_rd > 1)
      chk({t, ".throughput"}, last_rd - first_rd, 3 * (v.exp_rd - 1));
    if (v.irq_delay == 0 && ok_len) begin
      chk({t, ".t16_mode_cycles"}, mode_cnt_t - mdt_b, 16);
      chk({t, ".t16_err"},         err_t, 1);
      chk({t, ".t16_done"},        done_cnt_t - dnt_b, 1);
      chk({t, ".t16_reads"},       rd_cnt_t - rdt_b, 0);
    end
    $display("job %0d len=%0d cmd=%0d irq=%0d wr=%0d rd=%0d mode=%0d err=%0b",
             tag, v.len, v.cmd, v.irq_delay, wr_cnt - wr_b, rd_cnt - rd_b, mode_cnt - md_b, err);
  endtask

  task automatic check_idle(input string t);
    chk({t, ".busy"},        busy, 0);
    chk({t, ".done"},        done, 0);
    chk({t, ".err"},         err, 0);
    chk({t, ".in_ready"},    in_ready, 0);
    chk({t, ".out_valid"},   out_valid, 0);
    chk({t, ".out_data"},    out_data, 0);
    chk({t, ".ap_write_en"}, ap_write_en, 0);
    chk({t, ".ap_read_en"},  ap_read_en, 0);
    chk({t, ".ap_mode"},     ap_mode, 0);
    chk({t, ".ap_addr"},     ap_addr, 0);
    chk({t, ".ap_data"},     ap_data, 0);
    chk({t, ".ap_sel_col"},  ap_sel_col, 0);
    chk({t, ".ap_cmd"},      ap_cmd, 0);
    $display("reset check %s busy=%0b ap_mode=%0b", t, busy, ap_mode);
  endtask

  initial begin
    int m;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    out_ready = 1'b0; ap_state_irq = 1'b0; job_cmd = 3'd0; job_len = '0;

    vecs[0] = '{4,   3, 20,   0, 0, 8,    4,   20,   0};
    vecs[1] = '{1,   1, 1,    0, 0, 2,    1,   1,    0};
    vecs[2] = '{3,   5, 7,    1, 0, 6,    3,   7,    0};
    vecs[3] = '{512, 2, 3,    2, 1, 1024, 512, 3,    0};
    vecs[4] = '{0,   0, 0,    0, 0, 0,    0,   0,    0};
    vecs[5] = '{600, 4, 0,    0, 0, 0,    0,   0,    1};
    vecs[6] = '{2,   7, 0,    0, 1, 4,    0,   4096, 1};
    vecs[7] = '{5,   4, 4096, 0, 0, 10,   5,   4096, 0};

    repeat (3) @(posedge clk);
    #1;
    check_idle("por");
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;

    for (int v = 0; v < 8; v++) run_job(vecs[v], v);

    // Abort in LOAD_B with a write in progress, then a clean job.
    gen_data(4); cur_len = 4; cur_cmd = 3;
    start_job(4, 3);
    feed(6, 0, "rst_loadb");
    in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    chk("rst_loadb.pre_write", ap_write_en, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_loadb");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_loadb.post_write", ap_write_en, 0);
    chk("rst_loadb.post_busy", busy, 0);
    @(posedge clk); #1 in_valid = 1'b0; in_data = '0;
    run_job(vecs[0], 8);

    // Abort in RUN: ap_mode must fall without waiting for a clock edge.
    gen_data(2); cur_len = 2; cur_cmd = 6;
    start_job(2, 6);
    feed(4, 0, "rst_run");
    m = 0;
    for (int c = 0; c < 20 && m < 5; c++) begin
      @(negedge clk);
      if (ap_mode) m++;
    end
    chk("rst_run.pre_mode", ap_mode, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_run");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_run.post_mode", ap_mode, 0);
    chk("rst_run.post_read", ap_read_en, 0);
    chk("rst_run.post_write", ap_write_en, 0);
    run_job(vecs[1], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
